// File: rtl/nco_multi_if.sv
// Control/write bus and per-channel outputs of the multi-channel NCO.
interface nco_multi_if #(
  parameter int unsigned CH   = 4,
  parameter int unsigned PH_W = 10
);
  logic                 EN;
  logic                 SYNC;
  logic                 UPDATE;
  logic                 WR_EN;
  logic [2:0]           WR_CH;
  logic [1:0]           WR_SEL;
  logic [15:0]          WR_DATA;
  logic [CH-1:0]        FREQ_OUT;
  logic [CH*PH_W-1:0]   PHASE_OUT;
  logic [CH-1:0]        WRAP;

  modport master (
    output EN, SYNC, UPDATE, WR_EN, WR_CH, WR_SEL, WR_DATA,
    input  FREQ_OUT, PHASE_OUT, WRAP
  );

  modport slave (
    input  EN, SYNC, UPDATE, WR_EN, WR_CH, WR_SEL, WR_DATA,
    output FREQ_OUT, PHASE_OUT, WRAP
  );
endinterface

// File: rtl/nco_multi.sv
// Multi-channel phase accumulator NCO with double-buffered frequency/offset
// registers, global sync restart and registered phase/square/wrap outputs.
module nco_multi #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CH    = 4,
  parameter int unsigned PH_W  = 10
) (
  input  logic         CLK,
  input  logic         RST_N,
  nco_multi_if.slave   bus
);

  localparam int unsigned HI_W = ACC_W - 16;

  logic [CH-1:0][ACC_W-1:0] sh_freq_q, sh_offs_q;
  logic [CH-1:0][ACC_W-1:0] sh_freq_d, sh_offs_d;
  logic [CH-1:0][ACC_W-1:0] act_freq_q, act_offs_q;
  logic [CH-1:0][ACC_W-1:0] acc_q;
  logic [CH-1:0][ACC_W:0]   acc_sum;
  logic [CH-1:0][ACC_W-1:0] phase_sum;
  logic [CH-1:0]            freq_out_q, wrap_q;
  logic [CH*PH_W-1:0]       phase_q;
  logic                     unused_bits;

  // Shadow next-state; also feeds the active registers so a write coinciding
  // with UPDATE is committed in the same cycle. Channels >= CH never match.
  always_comb begin
    sh_freq_d = sh_freq_q;
    sh_offs_d = sh_offs_q;
    for (int unsigned k = 0; k < CH; k++) begin
      if (bus.WR_EN && (32'(bus.WR_CH) == k)) begin
        case (bus.WR_SEL)
          2'd0:    sh_freq_d[k][15:0]       = bus.WR_DATA;
          2'd1:    sh_freq_d[k][ACC_W-1:16] = bus.WR_DATA[HI_W-1:0];
          2'd2:    sh_offs_d[k][15:0]       = bus.WR_DATA;
          default: sh_offs_d[k][ACC_W-1:16] = bus.WR_DATA[HI_W-1:0];
        endcase
      end
    end
  end

  // Accumulate with carry-out, and offset phase from the current state.
  always_comb begin
    acc_sum   = '0;
    phase_sum = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      acc_sum[k]   = {1'b0, acc_q[k]} + {1'b0, act_freq_q[k]};
      phase_sum[k] = acc_q[k] + act_offs_q[k];
    end
  end

  // Low phase bits and spare write-data bits are intentionally dropped.
  assign unused_bits = ^{phase_sum, bus.WR_DATA};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sh_freq_q  <= '0;
      sh_offs_q  <= '0;
      act_freq_q <= '0;
      act_offs_q <= '0;
      acc_q      <= '0;
      freq_out_q <= '0;
      wrap_q     <= '0;
      phase_q    <= '0;
    end else begin
      sh_freq_q <= sh_freq_d;
      sh_offs_q <= sh_offs_d;
      if (bus.UPDATE) begin
        act_freq_q <= sh_freq_d;
        act_offs_q <= sh_offs_d;
      end
      for (int unsigned k = 0; k < CH; k++) begin
        if (bus.SYNC) begin
          acc_q[k] <= '0;
        end else if (bus.EN) begin
          acc_q[k] <= acc_sum[k][ACC_W-1:0];
        end
        wrap_q[k]                 <= bus.EN & ~bus.SYNC & acc_sum[k][ACC_W];
        freq_out_q[k]             <= phase_sum[k][ACC_W-1];
        phase_q[k*PH_W +: PH_W]   <= phase_sum[k][ACC_W-1 -: PH_W];
      end
    end
  end

  assign bus.FREQ_OUT  = freq_out_q;
  assign bus.PHASE_OUT = phase_q;
  assign bus.WRAP      = wrap_q;

endmodule

// File: tb/tb_nco_multi.sv
// Directed bench for nco_multi (ACC_W=32, CH=4, PH_W=10) with hand-computed expectations.
module tb_nco_multi;

  logic CLK = 1'b0;
  logic RST_N;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 CLK = ~CLK;

  nco_multi_if #(.CH(4), .PH_W(10)) bus ();

  nco_multi #(.ACC_W(32), .CH(4), .PH_W(10)) u_dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [1:0] sel, input logic [15:0] data,
                    input logic upd);
    bus.WR_EN   = 1'b1;
    bus.WR_CH   = ch;
    bus.WR_SEL  = sel;
    bus.WR_DATA = data;
    bus.UPDATE  = upd;
    cyc();
    bus.WR_EN   = 1'b0;
    bus.UPDATE  = 1'b0;
  endtask

  function automatic logic [9:0] ph(input int k);
    return bus.PHASE_OUT[k*10 +: 10];
  endfunction

  logic       fo_pat   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic       wrap_pat [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [9:0] ph_pat   [4] = '{10'h000, 10'h100, 10'h200, 10'h300};
  logic       dec_wrap [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [9:0] dec_ph   [4] = '{10'h000, 10'h3FF, 10'h3FF, 10'h3FF};

  initial begin
    bus.EN = 1'b0; bus.SYNC = 1'b0; bus.UPDATE = 1'b0; bus.WR_EN = 1'b0;
    bus.WR_CH = '0; bus.WR_SEL = '0; bus.WR_DATA = '0;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    cyc(); cyc();
    check("rst_freq_out", 64'(bus.FREQ_OUT), 64'h0);
    check("rst_phase", 64'(bus.PHASE_OUT), 64'h0);
    check("rst_wrap", 64'(bus.WRAP), 64'h0);
    RST_N = 1'b1;

    // ch0 quarter-rate, committed with write-through
    wr(3'd0, 2'd1, 16'h4000, 1'b1);
    bus.EN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("p4_freq_out", 64'(bus.FREQ_OUT), 64'({3'b000, fo_pat[i%4]}));
      check("p4_wrap", 64'(bus.WRAP), 64'({3'b000, wrap_pat[i%4]}));
      check("p4_phase0", 64'(ph(0)), 64'(ph_pat[i%4]));
    end
    bus.EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("hold_wrap", 64'(bus.WRAP), 64'h0);
      check("hold_phase0", 64'(ph(0)), 64'h0);
    end

    // ch1 freq/offset through shadow, then UPDATE and SYNC
    wr(3'd1, 2'd0, 16'h1000, 1'b0);
    wr(3'd1, 2'd1, 16'h0000, 1'b0);
    wr(3'd1, 2'd2, 16'h0000, 1'b0);
    wr(3'd1, 2'd3, 16'h8000, 1'b0);
    cyc();
    check("shadow_iso_phase", 64'(bus.PHASE_OUT), 64'h0);
    bus.UPDATE = 1'b1;
    cyc();
    bus.UPDATE = 1'b0;
    check("upd_latency", 64'(bus.FREQ_OUT), 64'h0);
    bus.SYNC = 1'b1; bus.EN = 1'b1;
    cyc();
    bus.SYNC = 1'b0; bus.EN = 1'b0;
    cyc();
    check("sync_freq_out", 64'(bus.FREQ_OUT), 64'h2);
    check("sync_phase", 64'(bus.PHASE_OUT), 64'h80000);
    check("sync_wrap", 64'(bus.WRAP), 64'h0);

    // uncommitted ch0 rate change must not take effect
    wr(3'd0, 2'd1, 16'h8000, 1'b0);
    bus.EN = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      check("shadow_fo0", 64'(bus.FREQ_OUT[0]), 64'(fo_pat[i%4]));
      check("shadow_wrap0", 64'(bus.WRAP[0]), 64'(wrap_pat[i%4]));
    end
    bus.EN = 1'b0; bus.UPDATE = 1'b1;
    cyc();
    bus.UPDATE = 1'b0; bus.EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("newrate_fo0", 64'(bus.FREQ_OUT[0]), 64'(i % 2));
      check("newrate_wrap0", 64'(bus.WRAP[0]), 64'(i % 2));
    end
    bus.EN = 1'b0;

    // ch2 all-ones frequency counts down
    wr(3'd2, 2'd0, 16'hFFFF, 1'b0);
    wr(3'd2, 2'd1, 16'hFFFF, 1'b1);
    bus.SYNC = 1'b1;
    cyc();
    bus.SYNC = 1'b0; bus.EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("dec_wrap2", 64'(bus.WRAP[2]), 64'(dec_wrap[i]));
      check("dec_phase2", 64'(ph(2)), 64'(dec_ph[i]));
    end
    bus.EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("frozen_wrap", 64'(bus.WRAP), 64'h0);
      check("frozen_phase2", 64'(ph(2)), 64'h3FF);
    end

    // write + update + sync in one cycle
    bus.WR_EN = 1'b1; bus.WR_CH = 3'd2; bus.WR_SEL = 2'd2; bus.WR_DATA = 16'h0001;
    bus.UPDATE = 1'b1; bus.SYNC = 1'b1;
    cyc();
    bus.WR_EN = 1'b0; bus.UPDATE = 1'b0; bus.SYNC = 1'b0;
    check("wus_wrap", 64'(bus.WRAP), 64'h0);
    cyc();
    check("wus_phase2", 64'(ph(2)), 64'h0);
    bus.EN = 1'b1;
    cyc(); cyc();
    check("wus_offs_carry", 64'(ph(2)), 64'h0);
    cyc();
    check("wus_offs_next", 64'(ph(2)), 64'h3FF);
    bus.EN = 1'b0;

    // out-of-range channel write must not alias onto ch1
    wr(3'd5, 2'd3, 16'h0000, 1'b1);
    cyc(); cyc();
    check("oor_fo1", 64'(bus.FREQ_OUT[1]), 64'h1);
    check("oor_phase1", 64'(ph(1)), 64'h200);

    // asynchronous reset mid-run
    bus.EN = 1'b1;
    cyc(); cyc();
    check("pre_rst_fo1", 64'(bus.FREQ_OUT[1]), 64'h1);
    #3 RST_N = 1'b0;
    #1;
    check("async_rst_freq_out", 64'(bus.FREQ_OUT), 64'h0);
    check("async_rst_phase", 64'(bus.PHASE_OUT), 64'h0);
    check("async_rst_wrap", 64'(bus.WRAP), 64'h0);
    cyc();
    RST_N = 1'b1;
    bus.UPDATE = 1'b1;
    cyc();
    bus.UPDATE = 1'b0;
    cyc(); cyc(); cyc();
    check("post_rst_phase", 64'(bus.PHASE_OUT), 64'h0);
    check("post_rst_freq_out", 64'(bus.FREQ_OUT), 64'h0);
    wr(3'd0, 2'd1, 16'h8000, 1'b1);
    cyc(); cyc();
    check("post_rst_run_fo", 64'(bus.FREQ_OUT), 64'h1);
    check("post_rst_run_wrap", 64'(bus.WRAP), 64'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
